// File: rtl/mlp_infer_engine.sv
`default_nettype none
// ============================================================================
// Module   : mlp_infer_engine
// Brief    : Two-layer dense inference engine (input -> ReLU hidden -> output
//            -> argmax). Pixels stream in on valid/ready; weight rows are read
//            from external synchronous ROMs; bias rows use an implicit input 1.
// Revision : 1.0 - initial release
// ============================================================================
module mlp_infer_engine #(
    parameter int N_IN  = 784,
    parameter int N_HID = 32,
    parameter int N_OUT = 10,
    parameter int DW    = 32,
    parameter int ACC_W = 64,
    parameter int FRAC  = 0,
    localparam int AW1  = $clog2(N_IN + 1),
    localparam int AW2  = $clog2(N_HID + 1),
    localparam int CW   = $clog2(N_OUT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    output logic [AW1-1:0]        w1_addr,
    input  logic [N_HID*DW-1:0]   w1_data,
    output logic [AW2-1:0]        w2_addr,
    input  logic [N_OUT*DW-1:0]   w2_data,
    output logic [N_OUT*DW-1:0]   results,
    output logic [CW-1:0]         class_idx,
    output logic                  class_valid
);

    localparam logic [3:0] c_IDLE    = 4'd0;
    localparam logic [3:0] c_L1      = 4'd1;
    localparam logic [3:0] c_L1_BIAS = 4'd2;
    localparam logic [3:0] c_L1_WAIT = 4'd3;
    localparam logic [3:0] c_RELU    = 4'd4;
    localparam logic [3:0] c_L2      = 4'd5;
    localparam logic [3:0] c_L2_WAIT = 4'd6;
    localparam logic [3:0] c_ARGMAX  = 4'd7;
    localparam logic [3:0] c_DONE    = 4'd8;

    // Saturation bounds of a DW-bit signed value, expressed at accumulator width
    localparam logic signed [ACC_W-1:0] c_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [3:0]                state_q, state_d;
    logic [AW1-1:0]            w1_addr_q, w1_addr_d;
    logic [AW2-1:0]            w2_addr_q, w2_addr_d;
    logic signed [DW-1:0]      pix_q, pix_d;
    logic                      mac1_en_q, mac1_en_d;
    logic signed [DW-1:0]      val2_q, val2_d;
    logic                      mac2_en_q, mac2_en_d;
    logic signed [ACC_W-1:0]   acc1_q [N_HID];
    logic signed [ACC_W-1:0]   acc1_d [N_HID];
    logic signed [ACC_W-1:0]   acc2_q [N_OUT];
    logic signed [ACC_W-1:0]   acc2_d [N_OUT];
    logic signed [DW-1:0]      hid_q  [N_HID];
    logic signed [DW-1:0]      hid_d  [N_HID];
    logic signed [DW-1:0]      res_q  [N_OUT];
    logic signed [DW-1:0]      res_d  [N_OUT];
    logic [CW-1:0]             scan_q, scan_d;
    logic signed [DW-1:0]      best_q, best_d;
    logic [CW-1:0]             cls_q, cls_d;
    logic                      cvalid_q, cvalid_d;

    // Shift out fraction bits, optionally apply ReLU, clamp to DW signed range
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] v,
                                                     input logic relu);
        logic signed [ACC_W-1:0] s;
        s = v >>> FRAC;
        if (relu && (s < 0)) s = '0;
        if (s > c_MAX) s = c_MAX;
        if (s < c_MIN) s = c_MIN;
        return s[DW-1:0];
    endfunction

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= c_IDLE;
            w1_addr_q <= '0;
            w2_addr_q <= '0;
            pix_q     <= '0;
            mac1_en_q <= 1'b0;
            val2_q    <= '0;
            mac2_en_q <= 1'b0;
            scan_q    <= '0;
            best_q    <= '0;
            cls_q     <= '0;
            cvalid_q  <= 1'b0;
            for (int h = 0; h < N_HID; h++) begin
                acc1_q[h] <= '0;
                hid_q[h]  <= '0;
            end
            for (int o = 0; o < N_OUT; o++) begin
                acc2_q[o] <= '0;
                res_q[o]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            w1_addr_q <= w1_addr_d;
            w2_addr_q <= w2_addr_d;
            pix_q     <= pix_d;
            mac1_en_q <= mac1_en_d;
            val2_q    <= val2_d;
            mac2_en_q <= mac2_en_d;
            scan_q    <= scan_d;
            best_q    <= best_d;
            cls_q     <= cls_d;
            cvalid_q  <= cvalid_d;
            for (int h = 0; h < N_HID; h++) begin
                acc1_q[h] <= acc1_d[h];
                hid_q[h]  <= hid_d[h];
            end
            for (int o = 0; o < N_OUT; o++) begin
                acc2_q[o] <= acc2_d[o];
                res_q[o]  <= res_d[o];
            end
        end
    end

    // Next-state sequencing through the two layers and the argmax scan
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:    if (start) state_d = c_L1;
            c_L1:      if (in_valid && (w1_addr_q == AW1'(N_IN - 1))) state_d = c_L1_BIAS;
            c_L1_BIAS: state_d = c_L1_WAIT;
            c_L1_WAIT: state_d = c_RELU;
            c_RELU:    state_d = c_L2;
            c_L2:      if (w2_addr_q == AW2'(N_HID)) state_d = c_L2_WAIT;
            c_L2_WAIT: state_d = c_ARGMAX;
            c_ARGMAX:  if (scan_q == CW'(N_OUT - 1)) state_d = c_DONE;
            c_DONE:    state_d = c_IDLE;
            default:   state_d = c_IDLE;
        endcase
    end

    // Datapath: one-cycle-delayed MAC stage plus per-state register updates
    always_comb begin
        logic signed [2*DW-1:0] prod;
        logic signed [DW-1:0]   cand;

        w1_addr_d = w1_addr_q;
        w2_addr_d = w2_addr_q;
        pix_d     = pix_q;
        mac1_en_d = 1'b0;
        val2_d    = val2_q;
        mac2_en_d = 1'b0;
        scan_d    = scan_q;
        best_d    = best_q;
        cls_d     = cls_q;
        cvalid_d  = cvalid_q;
        acc1_d    = acc1_q;
        acc2_d    = acc2_q;
        hid_d     = hid_q;
        res_d     = res_q;
        prod      = '0;
        cand      = res_q[0];

        // ROM data for the address issued last cycle meets the operand registered then
        if (mac1_en_q) begin
            for (int h = 0; h < N_HID; h++) begin
                prod      = pix_q * $signed(w1_data[h*DW +: DW]);
                acc1_d[h] = acc1_q[h] + ACC_W'(prod);
            end
        end
        if (mac2_en_q) begin
            for (int o = 0; o < N_OUT; o++) begin
                prod      = val2_q * $signed(w2_data[o*DW +: DW]);
                acc2_d[o] = acc2_q[o] + ACC_W'(prod);
            end
        end

        case (state_q)
            c_IDLE: begin
                if (start) begin
                    w1_addr_d = '0;
                    cvalid_d  = 1'b0;
                    for (int h = 0; h < N_HID; h++) acc1_d[h] = '0;
                    for (int o = 0; o < N_OUT; o++) acc2_d[o] = '0;
                end
            end
            c_L1: begin
                if (in_valid) begin
                    pix_d     = $signed(in_data);
                    mac1_en_d = 1'b1;
                    w1_addr_d = w1_addr_q + AW1'(1);
                end
            end
            c_L1_BIAS: begin
                pix_d     = DW'(1);
                mac1_en_d = 1'b1;
            end
            c_RELU: begin
                for (int h = 0; h < N_HID; h++) hid_d[h] = sat_dw(acc1_q[h], 1'b1);
                w2_addr_d = '0;
            end
            c_L2: begin
                val2_d = DW'(1);
                for (int h = 0; h < N_HID; h++) begin
                    if (w2_addr_q == AW2'(h)) val2_d = hid_q[h];
                end
                mac2_en_d = 1'b1;
                if (w2_addr_q != AW2'(N_HID)) w2_addr_d = w2_addr_q + AW2'(1);
            end
            c_L2_WAIT: begin
                // acc2_d already carries the bias-row MAC completing this cycle
                for (int o = 0; o < N_OUT; o++) res_d[o] = sat_dw(acc2_d[o], 1'b0);
                scan_d = '0;
            end
            c_ARGMAX: begin
                for (int o = 0; o < N_OUT; o++) begin
                    if (scan_q == CW'(o)) cand = res_q[o];
                end
                // Strictly greater keeps the lowest index on ties
                if ((scan_q == '0) || (cand > best_q)) begin
                    best_d = cand;
                    cls_d  = scan_q;
                end
                if (scan_q == CW'(N_OUT - 1)) cvalid_d = 1'b1;
                else                          scan_d   = scan_q + CW'(1);
            end
            default: ;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        in_ready = (state_q == c_L1);
        busy     = (state_q != c_IDLE);
        done     = (state_q == c_DONE);
    end

    generate
        for (genvar o = 0; o < N_OUT; o++) begin : g_res
            assign results[o*DW +: DW] = res_q[o];
        end
    endgenerate

    assign w1_addr     = w1_addr_q;
    assign w2_addr     = w2_addr_q;
    assign class_idx   = cls_q;
    assign class_valid = cvalid_q;

endmodule
`default_nettype wire

// File: doc/mlp_infer_engine.md
# mlp_infer_engine

Parametrised two-layer dense inference engine (input → ReLU hidden → output → argmax) for the MNIST SoC, generalising the fixed 784-32-10 accelerator. Image pixels arrive on a valid/ready stream instead of a flat wide bus. Weight rows come from external synchronous ROMs; bias rows are injected internally. Scores and the winning class are returned behind a start/busy/done handshake driven by the CPU-side glue.

## Interface
- N_IN, 784: input elements per image, excluding bias
- N_HID, 32: hidden neurons, computed in parallel
- N_OUT, 10: output neurons, computed in parallel
- DW, 32: signed data, weight and score width
- ACC_W, 64: signed accumulator width
- FRAC, 0: fixed-point fraction bits; arithmetic right shift applied after each layer
- AW1 = clog2(N_IN+1), AW2 = clog2(N_HID+1), CW = clog2(N_OUT): derived widths
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin inference; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when results and class_idx are valid
- in_valid  in  1  pixel valid
- in_ready  out  1  engine accepts a pixel this cycle
- in_data  in  DW  signed pixel
- w1_addr  out  AW1  layer-1 weight row address; row N_IN is the bias row
- w1_data  in  N_HID*DW  layer-1 row, neuron h at bits [h*DW +: DW]; valid 1 cycle after w1_addr
- w2_addr  out  AW2  layer-2 weight row address; row N_HID is the bias row
- w2_data  in  N_OUT*DW  layer-2 row, neuron o at [o*DW +: DW]; valid 1 cycle after w2_addr
- results  out  N_OUT*DW  output scores, neuron o at [o*DW +: DW]
- class_idx  out  CW  argmax of results
- class_valid  out  1  high from done until the next accepted start

## Operation
- FSM: IDLE → L1 → L1_BIAS → L1_WAIT → RELU → L2 → L2_WAIT → ARGMAX → DONE → IDLE.
- IDLE: start=1 clears all accumulators and class_valid, then goes to L1. start is ignored in every other state.
- L1: in_ready=1. On each handshake k (0..N_IN-1), w1_addr=k and in_data is registered. Next cycle, acc1[h] += pix*w1_data[h] for every h. After N_IN handshakes, go to L1_BIAS.
- in_valid low in L1: no address advance, no MAC, in_ready stays 1.
- L1_BIAS: w1_addr=N_IN, with an implicit pixel value of 1. L1_WAIT absorbs the final MAC.
- RELU: hid[h] = sat_DW(max(0, acc1[h] >>> FRAC)), registered.
- L2: for j=0..N_HID, w2_addr=j, with value hid[j] (value 1 at j=N_HID). Next cycle, acc2[o] += value*w2_data[o]. L2_WAIT absorbs the final MAC, then results[o] = sat_DW(acc2[o] >>> FRAC) is registered.
- ARGMAX: scans o=0..N_OUT-1, one per cycle, using signed compare. The strictly greater value wins, so on a tie the lowest index is kept.
- DONE: done=1 and class_valid=1 for one cycle, then IDLE.
- Saturation clamps to [-2^(DW-1), 2^(DW-1)-1]. Products are full 2*DW and sign-extended into ACC_W. Accumulator wrap beyond ACC_W is not detected.
- results, class_idx and class_valid hold until the next accepted start.

## Timing
- Reset values: busy=0, done=0, in_ready=0, class_valid=0, class_idx=0, results=0, w1_addr=0, w2_addr=0; all accumulators and hid cleared; FSM in IDLE.
- Take the start cycle as 0, with in_valid held high. Pixels are accepted in cycles 1..N_IN. done=1 at cycle N_IN+N_HID+N_OUT+6, which is 832 for the defaults.
- Each in_valid-low cycle during L1 adds exactly one cycle to the latency.
- Weight ROMs are read every cycle, with no enable. The addresses are don't-care outside L1/L1_BIAS/L2, but are held stable there.
- reset asserted in any state: all outputs return to reset values on the next edge, and the partially streamed image is discarded.
- start in the same cycle as done, or while busy: ignored. A new start is accepted from IDLE, the cycle after done at the earliest.

## Test plan
- All tests use N_IN=4, N_HID=2, N_OUT=3, FRAC=0 unless stated.
- Pixels 1,2,3,4; layer-1 rows {1,1}×4 plus bias {0,-20}; layer-2 identity-like rows plus bias {0,0,5} → hid={10,0}, results={10,0,5}, class_idx=0. done at cycle 15.
- Same stimulus with in_valid low for 3 cycles between pixels 2 and 3 → identical results; done at cycle 18; in_ready stays high throughout L1.
- Tie: results={7,7,-1} → class_idx=0. All results negative {-3,-9,-2} → class_idx=2.
- Saturation with DW=8: a layer-2 sum of 300 → results[o]=127; a sum of -300 → -128. FRAC=2 with acc1=13 → hid=3.
- reset mid-L2 → all outputs 0 next cycle. A fresh start then yields results matching a clean run. start pulsed while busy has no effect on results or latency.
- Defaults (784-32-10) with a golden model image → results and class_idx match the golden vector; done at cycle 832.
